adc_pair_axis_sequencer: RTL

- Samples both ADC channels on a programmable decimation tick.
- Converts each two's-complement sample to offset binary (0 = -10.0 V) and time-multiplexes the pair, A then B, onto a single AXI-Stream master.
- The downstream consumer is one shared Xilinx fixed-to-float IP instead of two.
- Sits between the ADC capture registers and the floating-point chain of the SPGD datapath; honours tready backpressure and flags dropped samples.

---
 rtl/spgd_pkg.sv | 16 +
 rtl/twos_to_ADC_offset.sv | 12 +
 rtl/adc_pair_axis_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD datapath: sequencer states, channel tags
// and the drop-counter width.
package spgd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } seq_state_t;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int unsigned DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/twos_to_ADC_offset.sv
// Two's-complement ADC sample to offset binary (all zeros = most negative
// input, -10.0 V).
module twos_to_ADC_offset #(
    parameter int unsigned ADC_WIDTH = 12
) (
    input  logic [ADC_WIDTH-1:0] twos,
    output logic [ADC_WIDTH-1:0] offset
);

    assign offset = {~twos[ADC_WIDTH-1], twos[ADC_WIDTH-2:0]};

endmodule

// File: rtl/adc_pair_axis_sequencer.sv
// Decimated ADC pair sampler: captures both channels on a tick and streams
// them as A then B beats on one AXI-Stream master, counting dropped ticks.
module adc_pair_axis_sequencer
    import spgd_pkg::*;
#(
    parameter int unsigned ADC_WIDTH        = 12,
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned DECIM_WIDTH      = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [ADC_WIDTH-1:0]        adc_a,
    input  logic [ADC_WIDTH-1:0]        adc_b,
    input  logic                        cfg_enable,
    input  logic [DECIM_WIDTH-1:0]      cfg_decim,
    input  logic                        overrun_clr,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        overrun,
    output logic [DROP_CNT_WIDTH-1:0]   drop_count
);

    seq_state_t             state;
    logic [DECIM_WIDTH-1:0] dec_cnt;
    logic [ADC_WIDTH-1:0]   conv_a;
    logic [ADC_WIDTH-1:0]   conv_b;
    logic [ADC_WIDTH-1:0]   cap_b;
    logic                   tick;
    logic                   accept;
    logic                   drop;

    twos_to_ADC_offset #(.ADC_WIDTH(ADC_WIDTH)) u_conv_a (.twos(adc_a), .offset(conv_a));
    twos_to_ADC_offset #(.ADC_WIDTH(ADC_WIDTH)) u_conv_b (.twos(adc_b), .offset(conv_b));

    // >= rather than == so lowering cfg_decim below the live count ticks at once.
    assign tick   = cfg_enable && (dec_cnt >= cfg_decim);
    assign accept = tick && ((state == IDLE) || ((state == SEND_B) && m_axis_tready));
    assign drop   = tick && !accept;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dec_cnt <= '0;
        end else if (!cfg_enable || tick) begin
            dec_cnt <= '0;
        end else begin
            dec_cnt <= dec_cnt + 1'b1;
        end
    end

    // The A beat register doubles as channel A's capture register; only B
    // needs a separate holding register while A is in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            cap_b         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= CH_A;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (accept) begin
            state         <= SEND_A;
            cap_b         <= conv_b;
            m_axis_tdata  <= AXIS_TDATA_WIDTH'(conv_a);
            m_axis_tuser  <= CH_A;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
        end else begin
            case (state)
                SEND_A: begin
                    if (m_axis_tready) begin
                        state        <= SEND_B;
                        m_axis_tdata <= AXIS_TDATA_WIDTH'(cap_b);
                        m_axis_tuser <= CH_B;
                        m_axis_tlast <= 1'b1;
                    end
                end
                SEND_B: begin
                    if (m_axis_tready) begin
                        state         <= IDLE;
                        m_axis_tuser  <= CH_A;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tvalid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A drop coinciding with overrun_clr restarts the count at one.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (overrun_clr) begin
                drop_count <= DROP_CNT_WIDTH'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (overrun_clr) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule
